// File: rtl/timer_dev.sv
// Programmable 32-bit down-counting timer on the data-memory bus with a level interrupt.
// Optional prescaler is compiled in when TIMER_PRESCALE_EN is defined.
module timer_dev #(
  parameter int unsigned PRESCALE = 32'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  data_type,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    CNT  = 2'b10,
    INT  = 2'b11
  } state_t;

  state_t      state_r;
  state_t      nextState_s;
  logic        ctrlEn_r;
  logic [1:0]  ctrlMode_r;
  logic        ctrlIm_r;
  logic [31:0] preset_r;
  logic [31:0] count_r;
  logic        irqFlag_r;
  logic        irq_r;

  logic        wrAccept_s;
  logic        wrCtrl_s;
  logic        wrPreset_s;
  logic        autoReload_s;
  logic        countZero_s;
  logic        tick_s;
  logic        loadCount_s;
  logic        decCount_s;
  logic        expire_s;
  logic        nextEn_s;
  logic [1:0]  nextMode_s;
  logic        nextIm_s;
  logic        nextFlag_s;
  logic        unusedAddrBits_s;

  if ((PRESCALE < 32'd1) || (PRESCALE > 32'd65535)) begin : gPrescaleRange
    $error("timer_dev: PRESCALE must lie in 1..65535");
  end

  assign wrAccept_s       = sel & we & (data_type == 4'b0000);
  assign wrCtrl_s         = wrAccept_s & (addr[3:2] == 2'd0);
  assign wrPreset_s       = wrAccept_s & (addr[3:2] == 2'd1);
  assign autoReload_s     = (ctrlMode_r == 2'b01);
  assign countZero_s      = (count_r == 32'd0);
  assign unusedAddrBits_s = ^{addr[31:4], addr[1:0]};

`ifdef TIMER_PRESCALE_EN
  localparam logic [15:0] PSC_LAST = 16'(PRESCALE - 32'd1);

  logic [15:0] psc_r;

  assign tick_s = (psc_r == PSC_LAST);

  // Prescale counter: restarts at LOAD, wraps on every tick while counting
  always_ff @(posedge clk) begin
    if (reset) begin
      psc_r <= 16'd0;
    end else if (state_r == LOAD) begin
      psc_r <= 16'd0;
    end else if (state_r == CNT) begin
      psc_r <= tick_s ? 16'd0 : (psc_r + 16'd1);
    end else begin
      psc_r <= psc_r;
    end
  end
`else
  assign tick_s = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state logic
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (ctrlEn_r) nextState_s = LOAD;
        else          nextState_s = IDLE;
      end
      LOAD: nextState_s = CNT;
      CNT: begin
        if (!ctrlEn_r)                  nextState_s = IDLE;
        else if (tick_s && countZero_s) nextState_s = INT;
        else                            nextState_s = CNT;
      end
      INT: begin
        if (autoReload_s && ctrlEn_r) nextState_s = LOAD;
        else                          nextState_s = IDLE;
      end
      default: nextState_s = IDLE;
    endcase
  end

  // FSM action decode
  always_comb begin
    loadCount_s = 1'b0;
    decCount_s  = 1'b0;
    expire_s    = 1'b0;
    case (state_r)
      LOAD: loadCount_s = 1'b1;
      CNT: begin
        if (ctrlEn_r && tick_s) begin
          expire_s   = countZero_s;
          decCount_s = ~countZero_s;
        end else begin
          expire_s   = 1'b0;
          decCount_s = 1'b0;
        end
      end
      default: begin
        loadCount_s = 1'b0;
        decCount_s  = 1'b0;
        expire_s    = 1'b0;
      end
    endcase
  end

  // CTRL next value: a bus write beats the one-shot hardware clear of EN
  always_comb begin
    nextEn_s   = ctrlEn_r;
    nextMode_s = ctrlMode_r;
    nextIm_s   = ctrlIm_r;
    if (wrCtrl_s) begin
      nextEn_s   = wd[0];
      nextMode_s = wd[2:1];
      nextIm_s   = wd[3];
    end else if (expire_s && !autoReload_s) begin
      nextEn_s = 1'b0;
    end else begin
      nextEn_s = ctrlEn_r;
    end
  end

  // Interrupt flag next value: expiry sets it, auto-reload drops it after INT, writes clear it
  always_comb begin
    nextFlag_s = irqFlag_r;
    if (expire_s) begin
      nextFlag_s = 1'b1;
    end else if ((state_r == INT) && autoReload_s) begin
      nextFlag_s = 1'b0;
    end else if (wrCtrl_s || wrPreset_s) begin
      nextFlag_s = 1'b0;
    end else begin
      nextFlag_s = irqFlag_r;
    end
  end

  // Control, flag and interrupt output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrlEn_r   <= 1'b0;
      ctrlMode_r <= 2'b00;
      ctrlIm_r   <= 1'b0;
      irqFlag_r  <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      ctrlEn_r   <= nextEn_s;
      ctrlMode_r <= nextMode_s;
      ctrlIm_r   <= nextIm_s;
      irqFlag_r  <= nextFlag_s;
      irq_r      <= nextFlag_s & nextIm_s;
    end
  end

  // PRESET register; a write mid-count only affects the next LOAD
  always_ff @(posedge clk) begin
    if (reset) begin
      preset_r <= 32'd0;
    end else if (wrPreset_s) begin
      preset_r <= wd;
    end else begin
      preset_r <= preset_r;
    end
  end

  // COUNT register; decrement is only decoded for a non-zero count, so it never wraps
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 32'd0;
    end else if (loadCount_s) begin
      count_r <= preset_r;
    end else if (decCount_s) begin
      count_r <= count_r - 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // Read mux, independent of sel/we
  always_comb begin
    rd = 32'd0;
    case (addr[3:2])
      2'd0:    rd = {28'd0, ctrlIm_r, ctrlMode_r, ctrlEn_r};
      2'd1:    rd = preset_r;
      2'd2:    rd = count_r;
      default: rd = 32'd0;
    endcase
  end

  assign irq = irq_r;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed vector table, hand-written corner sequences,
// and random bus traffic compared against a behavioural model of the timer.
module tb_timer_dev;

`ifdef TIMER_PRESCALE_EN
  localparam int PSC = 3;
`else
  localparam int PSC = 1;
`endif

  localparam int PH_WAIT = 0;
  localparam int PH_ARM  = 1;
  localparam int PH_RUN  = 2;
  localparam int PH_FIRE = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [3:0]  dataType = 4'b1111;
  logic [31:0] wd = 32'd0;
  logic [31:0] rd;
  logic        irq;

  timer_dev #(.PRESCALE(PSC)) dut (
    .clk(clk), .reset(reset), .sel(sel), .addr(addr), .we(we),
    .data_type(dataType), .wd(wd), .rd(rd), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [3:0]  mCtrl = 4'd0;
  logic [31:0] mPreset = 32'd0;
  logic [31:0] mCount = 32'd0;
  logic        mFlag = 1'b0;
  int          mPhase = PH_WAIT;
  int          mRunCycles = 0;

  typedef struct {
    logic        sel;
    logic        we;
    logic [3:0]  dt;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] expRd;
    logic        expIrq;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelRd(input logic [31:0] a);
    case (a[3:2])
      2'd0:    return {28'd0, mCtrl};
      2'd1:    return mPreset;
      2'd2:    return mCount;
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs presented during the cycle just ended
  task automatic modelStep();
    logic        wr;
    logic        autoMode;
    logic        en;
    logic        tick;
    logic        fire;
    logic [1:0]  off;
    logic [3:0]  nCtrl;
    logic [31:0] nCount;
    logic        nFlag;
    int          nPhase;
    int          nRun;
    if (reset) begin
      mCtrl = 4'd0; mPreset = 32'd0; mCount = 32'd0; mFlag = 1'b0;
      mPhase = PH_WAIT; mRunCycles = 0;
    end else begin
      wr       = sel && we && (dataType == 4'b0000);
      off      = addr[3:2];
      en       = mCtrl[0];
      autoMode = (mCtrl[2:1] == 2'b01);
      tick     = (((mRunCycles + 1) % PSC) == 0);
      fire     = (mPhase == PH_RUN) && en && tick && (mCount == 32'd0);
      nCtrl = mCtrl; nCount = mCount; nFlag = mFlag; nPhase = mPhase; nRun = mRunCycles;
      case (mPhase)
        PH_WAIT: nPhase = en ? PH_ARM : PH_WAIT;
        PH_ARM: begin
          nCount = mPreset; nRun = 0; nPhase = PH_RUN;
        end
        PH_RUN: begin
          if (!en) nPhase = PH_WAIT;
          else begin
            nRun = mRunCycles + 1;
            if (tick) begin
              if (mCount == 32'd0) nPhase = PH_FIRE;
              else nCount = mCount - 32'd1;
            end
          end
        end
        default: nPhase = (autoMode && en) ? PH_ARM : PH_WAIT;
      endcase
      if (wr && off == 2'd0) nCtrl = wd[3:0];
      else if (fire && !autoMode) nCtrl[0] = 1'b0;
      if (fire) nFlag = 1'b1;
      else if (mPhase == PH_FIRE && autoMode) nFlag = 1'b0;
      else if (wr && off <= 2'd1) nFlag = 1'b0;
      if (wr && off == 2'd1) mPreset = wd;
      mCtrl = nCtrl; mCount = nCount; mFlag = nFlag; mPhase = nPhase; mRunCycles = nRun;
    end
  endtask

  // One bus cycle: drive, sample mid-cycle, optionally compare with the model, then clock
  task automatic cyc(input logic s, input logic w, input logic [3:0] dt, input logic [31:0] a,
                     input logic [31:0] d, input bit chk, output logic [31:0] rdS, output logic irqS);
    sel = s; we = w; dataType = dt; addr = a; wd = d;
    #3;
    rdS = rd;
    irqS = irq;
    if (chk) begin
      check("model_rd", rd, modelRd(a));
      check("model_irq", {31'd0, irq}, {31'd0, mFlag & mCtrl[3]});
    end
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic wrReg(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic        i;
    cyc(1'b1, 1'b1, 4'b0000, a, d, 1'b1, r, i);
  endtask

  task automatic rdReg(input logic [31:0] a, output logic [31:0] r, output logic i);
    cyc(1'b1, 1'b0, 4'b0000, a, 32'd0, 1'b1, r, i);
  endtask

  task automatic doReset();
    logic [31:0] r;
    logic        i;
    reset = 1'b1;
    cyc(1'b0, 1'b0, 4'b1111, 32'd0, 32'd0, 1'b0, r, i);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic        i;
    logic        prev;
    int          rises[$];
    int          firstIrq;
    logic [1:0]  off;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  dt;
    int          pick;

    #1;
    doReset();

`ifndef TIMER_PRESCALE_EN
    // Reset reads, then one-shot PRESET=5 / CTRL=0x9 sequence (entry 4 is cycle 0)
    tbl[0]  = '{1'b1, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'b0000, 32'h4, 32'h0, 32'h0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 4'b0000, 32'h8, 32'h0, 32'h0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 4'b0000, 32'hC, 32'h0, 32'h0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 4'b0000, 32'h4, 32'h5, 32'h0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 4'b0000, 32'h0, 32'h9, 32'h0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 4'b0000, 32'h8, 32'h0, 32'h0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 4'b0000, 32'h8, 32'h0, 32'h0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 4'b0000, 32'h8, 32'h0, 32'h5, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 4'b0000, 32'h8, 32'h0, 32'h4, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 4'b0000, 32'h8, 32'h0, 32'h3, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 4'b0000, 32'h8, 32'h0, 32'h2, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 4'b0000, 32'h8, 32'h0, 32'h1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 4'b0000, 32'h8, 32'h0, 32'h0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 4'b0000, 32'h8, 32'h0, 32'h0, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h8, 1'b1};
    tbl[16] = '{1'b1, 1'b1, 4'b0000, 32'h4, 32'h7, 32'h5, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 4'b0000, 32'h4, 32'h0, 32'h7, 1'b0};
    for (int k = 0; k < 18; k++) begin
      cyc(tbl[k].sel, tbl[k].we, tbl[k].dt, tbl[k].addr, tbl[k].wd, 1'b1, r, i);
      check($sformatf("tbl%0d_rd", k), r, tbl[k].expRd);
      check($sformatf("tbl%0d_irq", k), {31'd0, i}, {31'd0, tbl[k].expIrq});
    end
`endif

    // Auto-reload: single-cycle pulses at a fixed period, EN stays set
    doReset();
    wrReg(32'h4, 32'd5);
    wrReg(32'h0, 32'hB);
    prev = 1'b0;
    for (int k = 0; k < 60; k++) begin
      rdReg(32'h0, r, i);
      check("ar_pulse_width", {31'd0, i & prev}, 32'd0);
      if (i && !prev) rises.push_back(k);
      prev = i;
    end
    check("ar_pulse_count_ge3", (rises.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
    for (int j = 1; j < rises.size(); j++)
      check("ar_period", rises[j] - rises[j-1], (5 + 1) * PSC + 2);
    check("ar_ctrl", r, 32'hB);

    // Rejected writes: sub-word, no-access, unselected, COUNT
    doReset();
    cyc(1'b1, 1'b1, 4'b0010, 32'h0, 32'h1, 1'b1, r, i);
    cyc(1'b1, 1'b1, 4'b1111, 32'h0, 32'h1, 1'b1, r, i);
    cyc(1'b0, 1'b1, 4'b0000, 32'h0, 32'h1, 1'b1, r, i);
    rdReg(32'h0, r, i);
    check("badwr_ctrl", r, 32'h0);
    wrReg(32'h8, 32'h1234);
    rdReg(32'h8, r, i);
    check("badwr_count", r, 32'h0);
    for (int k = 0; k < 4; k++) rdReg(32'h8, r, i);
    check("badwr_count_idle", r, 32'h0);

    // PRESET=0 with IM=0: expiry is silent, and the IM=1 write clears the flag
    doReset();
    wrReg(32'h0, 32'h1);
    for (int k = 0; k < 6; k++) begin
      rdReg(32'h0, r, i);
      check("p0_irq_masked", {31'd0, i}, 32'd0);
    end
    check("p0_en_cleared", r, 32'h0);
    wrReg(32'h0, 32'h8);
    for (int k = 0; k < 3; k++) begin
      rdReg(32'h0, r, i);
      check("p0_irq_after_im", {31'd0, i}, 32'd0);
    end
    check("p0_ctrl", r, 32'h8);

    // Clearing EN mid-count freezes COUNT
    doReset();
    wrReg(32'h4, 32'd10);
    wrReg(32'h0, 32'h1);
    for (int k = 0; k < 4; k++) rdReg(32'h8, r, i);
    wrReg(32'h0, 32'h0);
    for (int k = 0; k < 5; k++) rdReg(32'h8, r, i);
`ifndef TIMER_PRESCALE_EN
    check("freeze_count", r, 32'd7);
`endif

    // Reset mid-operation
    wrReg(32'h4, 32'd3);
    wrReg(32'h0, 32'hB);
    for (int k = 0; k < 5; k++) rdReg(32'h8, r, i);
    doReset();
    for (int k = 0; k < 4; k++) begin
      rdReg(32'(k * 4), r, i);
      check("rst_mid_rd", r, 32'h0);
    end
    for (int k = 0; k < 10; k++) begin
      rdReg(32'h8, r, i);
      check("rst_mid_irq", {31'd0, i}, 32'd0);
    end

`ifdef TIMER_PRESCALE_EN
    // Prescaled first interrupt: PRESET=2 in cycle 0, EN in cycle 1
    doReset();
    wrReg(32'h4, 32'd2);
    wrReg(32'h0, 32'h9);
    firstIrq = -1;
    for (int k = 2; k < 30; k++) begin
      rdReg(32'h8, r, i);
      if (i && firstIrq < 0) firstIrq = k;
    end
    check("psc_first_irq", firstIrq, 13);
`endif

    // Random bus traffic against the model
    doReset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        doReset();
        continue;
      end
      off = 2'($urandom_range(0, 3));
      a = $urandom;
      a[3:2] = off;
      pick = $urandom_range(0, 7);
      dt = (pick == 6) ? 4'b0010 : ((pick == 7) ? 4'b1111 : 4'b0000);
      d = $urandom;
      if (off == 2'd1) d = 32'($urandom_range(0, 6));
      if (off == 2'd0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      cyc(($urandom_range(0, 5) != 0), ($urandom_range(0, 4) == 0), dt, a, d, 1'b1, r, i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
